alu_input_loader: RTL and testbench
===================================

# alu_input_loader

Operand/opcode front end for the ALU on the lab board. It samples the board slide switches and three push-buttons, then synchronises and debounces each button. On each clean press it latches the switch value into the A, B or Op register, which drives the ALU inputs directly. It is the only sequential stage in front of the ALU; the ALU result still goes straight to the LEDs.

## Interface

Parameters:
- size, 8: operand width; must be ≥ 6 so the opcode fits in the switches.
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required before a button level is accepted; must be ≥ 2.

Ports:
- Clk, input, 1: single clock for all state.
- Rst_n, input, 1: reset, asynchronous and active-low.
- Switches, input, size: raw slide switches; asynchronous, not debounced.
- BtnA, input, 1: raw button, active-high; loads A.
- BtnB, input, 1: raw button, active-high; loads B.
- BtnOp, input, 1: raw button, active-high; loads Op.
- A, output, size: registered operand A, signed.
- B, output, size: registered operand B, signed.
- Op, output, 6: registered opcode.
- Loaded, output, 3: sticky flags {Op, B, A}, set on the first load of each register.
- Ready, output, 1: &Loaded.

## Operation

- Each button has its own path: 2-FF synchroniser → debounce counter → stable level → rising-edge detector → one-cycle load pulse.
- Debounce rule:
  - While the synced level equals the stable level, the counter holds 0.
  - While it differs, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES−1 and the level still differs, the stable level flips and the counter returns to 0.
  - Any bounce back to the stable level clears the counter.
- Switches pass through a 2-FF synchroniser (size bits). Loads use the synchronised value.
- Load actions:
  - A ← sw_sync on a BtnA pulse.
  - B ← sw_sync on a BtnB pulse.
  - Op ← sw_sync[5:0] on a BtnOp pulse.
- Each load also sets the matching Loaded bit. Loaded bits clear only on reset.
- Holding a button produces exactly one load. The release is debounced the same way but produces no pulse.
- Simultaneous pulses on two or three buttons in the same cycle: every pulsed register loads the same sw_sync value. No priority, no loss.
- A press shorter than DEBOUNCE_CYCLES synced cycles produces no load.
- No counter wrap. The counter width is clog2(DEBOUNCE_CYCLES) and its value never exceeds DEBOUNCE_CYCLES−1.

## Timing

- Reset values, applied immediately on Rst_n low with no clock needed:
  - A = 0, B = 0.
  - Op = 6'b000000, so the ALU passes A and the LEDs show 0.
  - Loaded = 3'b000, Ready = 0.
  - Synchronisers, stable levels and counters all 0.
- Latency: take the first Clk edge that samples a button high, with the button held clean. The output register updates on edge number DEBOUNCE_CYCLES+3 (2 synchroniser + DEBOUNCE_CYCLES debounce + 1 load). Loaded updates on the same edge. Ready follows combinationally.
- Switch value captured: sw_sync at that load edge, i.e. the raw switches as they were 2 edges earlier.
- Reset mid-debounce: counter and stable level clear. After release the press must be re-qualified from scratch, and no spurious load follows.
- Reset released while a button is held: the held button counts as a new press and loads after the full latency.
- Outputs change only on Clk edges (or async reset) and never glitch between edges.

## Structure

- Shared package holds:
  - the Op encodings used by the ALU (ADD 6'b100000, SUB 6'b100010, AND 6'b100100, OR 6'b100101, XOR 6'b100110, SRA 6'b000011, SRL 6'b000010, NOR 6'b100111, PASS_A 6'b000000, PASS_B 6'b000001);
  - the default DEBOUNCE_CYCLES;
  - the Loaded bit indices (A=0, B=1, Op=2).
- One sub-module, button_debouncer: Clk, Rst_n, raw input, parameter DEBOUNCE_CYCLES; outputs the stable level and a one-cycle rise pulse. It is instantiated three times.
- Top level holds the switch synchroniser, the A/B/Op registers and Loaded.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4 and size=8.
- Reset: assert Rst_n=0 mid-cycle → A=0, B=0, Op=0, Loaded=0, Ready=0 with no clock edge.
- Clean press: Switches=8'h5A, BtnA high and held → A=8'h5A on edge 7, Loaded=3'b001, B and Op unchanged; holding 20 more cycles gives no further load.
- Bounce rejection: BtnB toggles high 2 cycles / low 1 cycle ×5, then stays high → B loads only after the final 4-cycle-stable run; exactly one load.
- Simultaneous: Switches=8'h22, BtnB and BtnOp rise on the same edge → B=8'h22 and Op=6'h22 on the same edge, Loaded=3'b110. After a later BtnA load, Ready=1.
- Reset mid-debounce: BtnA high for 3 cycles, Rst_n pulsed low, BtnA released → A stays 0 and no load occurs.
- Switch capture: Switches changes 8'h0F→8'hF0 exactly 1 edge before the load edge → A=8'h0F, showing the 2-stage synchroniser delay.

Source files
------------

// File: rtl/alu_input_loader_pkg.sv
// Shared definitions for the ALU operand/opcode front end: opcode encodings,
// default debounce length and Loaded flag bit positions.
package alu_input_loader_pkg;

    typedef enum logic [5:0] {
        OP_PASS_A = 6'b000000,
        OP_PASS_B = 6'b000001,
        OP_SRL    = 6'b000010,
        OP_SRA    = 6'b000011,
        OP_ADD    = 6'b100000,
        OP_SUB    = 6'b100010,
        OP_AND    = 6'b100100,
        OP_OR     = 6'b100101,
        OP_XOR    = 6'b100110,
        OP_NOR    = 6'b100111
    } alu_op_e;

    localparam int OP_W                    = 6;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

    localparam int LD_A  = 0;
    localparam int LD_B  = 1;
    localparam int LD_OP = 2;

endpackage

// File: rtl/alu_input_loader_button_debouncer.sv
// One push-button path: 2-FF synchroniser, stability counter, accepted level
// and a single-cycle pulse on each accepted rising transition.
module button_debouncer
    import alu_input_loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic btn_raw,
    output logic level,
    output logic rise
);

    localparam int               CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;
    logic             prev_q, prev_d;

    always_comb begin
        sync_d   = {sync_q[0], btn_raw};
        prev_d   = stable_q;
        stable_d = stable_q;
        cnt_d    = '0;
        // The counter only runs while the synced level disagrees with the
        // accepted one; on the final count it flips the level and restarts.
        if (sync_q[1] != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            prev_q   <= prev_d;
        end
    end

    assign level = stable_q;
    assign rise  = stable_q & ~prev_q;

endmodule

// File: rtl/alu_input_loader.sv
// ALU input front end: synchronises the slide switches and latches them into
// A, B or Op on a clean press of the matching button.
module alu_input_loader
    import alu_input_loader_pkg::*;
#(
    parameter int size            = 8,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic [size-1:0]        Switches,
    input  logic                   BtnA,
    input  logic                   BtnB,
    input  logic                   BtnOp,
    output logic signed [size-1:0] A,
    output logic signed [size-1:0] B,
    output logic [5:0]             Op,
    output logic [2:0]             Loaded,
    output logic                   Ready
);

    logic [2:0] btn_raw;
    logic [2:0] btn_level;
    logic [2:0] btn_rise;
    logic [2:0] load;

    logic [size-1:0]        sw_s1_q, sw_s1_d;
    logic [size-1:0]        sw_s2_q, sw_s2_d;
    logic signed [size-1:0] a_q, a_d;
    logic signed [size-1:0] b_q, b_d;
    logic [OP_W-1:0]        op_q, op_d;
    logic [2:0]             loaded_q, loaded_d;

    assign btn_raw[LD_A]  = BtnA;
    assign btn_raw[LD_B]  = BtnB;
    assign btn_raw[LD_OP] = BtnOp;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .Clk(Clk), .Rst_n(Rst_n), .btn_raw(btn_raw[LD_A]),
        .level(btn_level[LD_A]), .rise(btn_rise[LD_A])
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .Clk(Clk), .Rst_n(Rst_n), .btn_raw(btn_raw[LD_B]),
        .level(btn_level[LD_B]), .rise(btn_rise[LD_B])
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_op (
        .Clk(Clk), .Rst_n(Rst_n), .btn_raw(btn_raw[LD_OP]),
        .level(btn_level[LD_OP]), .rise(btn_rise[LD_OP])
    );

    // A pulse is only honoured while the accepted level is still high.
    assign load = btn_rise & btn_level;

    always_comb begin
        sw_s1_d  = Switches;
        sw_s2_d  = sw_s1_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        loaded_d = loaded_q | load;
        if (load[LD_A])  a_d  = $signed(sw_s2_q);
        if (load[LD_B])  b_d  = $signed(sw_s2_q);
        if (load[LD_OP]) op_d = sw_s2_q[OP_W-1:0];
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_PASS_A;
            loaded_q <= '0;
        end else begin
            sw_s1_q  <= sw_s1_d;
            sw_s2_q  <= sw_s2_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            loaded_q <= loaded_d;
        end
    end

    assign A      = a_q;
    assign B      = b_q;
    assign Op     = op_q;
    assign Loaded = loaded_q;
    assign Ready  = &loaded_q;

endmodule

// File: tb/tb_alu_input_loader.sv
// Bench for alu_input_loader: directed scenarios plus random button/switch
// activity, checked every cycle against a behavioural model of the loader.
module tb_alu_input_loader;

    localparam int SIZE = 8;
    localparam int N    = 4;

    logic                   Clk      = 1'b0;
    logic                   Rst_n    = 1'b1;
    logic [SIZE-1:0]        Switches = '0;
    logic                   BtnA     = 1'b0;
    logic                   BtnB     = 1'b0;
    logic                   BtnOp    = 1'b0;
    logic signed [SIZE-1:0] A;
    logic signed [SIZE-1:0] B;
    logic [5:0]             Op;
    logic [2:0]             Loaded;
    logic                   Ready;

    alu_input_loader #(.size(SIZE), .DEBOUNCE_CYCLES(N)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Switches(Switches),
        .BtnA(BtnA), .BtnB(BtnB), .BtnOp(BtnOp),
        .A(A), .B(B), .Op(Op), .Loaded(Loaded), .Ready(Ready)
    );

    always #5 Clk = ~Clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural model: a button level is accepted once the last N synced
    // samples (raw delayed by two edges) all disagree with it; an accepted
    // rise loads the register on the following edge with the switches as
    // sampled two edges before that load edge.
    logic [SIZE-1:0] m_a      = '0;
    logic [SIZE-1:0] m_b      = '0;
    logic [5:0]      m_op     = '0;
    logic [2:0]      m_loaded = '0;
    int              m_loads [3];

    initial begin : model
        logic [2:0]      d1, d2, stab, pend, rose, raw;
        logic [SIZE-1:0] sw1, sw2;
        logic [N-1:0]    hist [3];
        d1 = '0; d2 = '0; stab = '0; pend = '0; sw1 = '0; sw2 = '0;
        for (int b = 0; b < 3; b++) begin hist[b] = '0; m_loads[b] = 0; end
        forever begin
            @(posedge Clk or negedge Rst_n);
            if (!Rst_n) begin
                d1 = '0; d2 = '0; stab = '0; pend = '0; sw1 = '0; sw2 = '0;
                m_a = '0; m_b = '0; m_op = '0; m_loaded = '0;
                for (int b = 0; b < 3; b++) begin hist[b] = '0; m_loads[b] = 0; end
            end else begin
                raw = {BtnOp, BtnB, BtnA};
                if (pend[0]) begin m_a  = sw2;      m_loaded[0] = 1'b1; m_loads[0]++; end
                if (pend[1]) begin m_b  = sw2;      m_loaded[1] = 1'b1; m_loads[1]++; end
                if (pend[2]) begin m_op = sw2[5:0]; m_loaded[2] = 1'b1; m_loads[2]++; end
                for (int b = 0; b < 3; b++) begin
                    hist[b] = {hist[b][N-2:0], d2[b]};
                    rose[b] = 1'b0;
                    if (hist[b] == (stab[b] ? {N{1'b0}} : {N{1'b1}})) begin
                        stab[b] = ~stab[b];
                        rose[b] = stab[b];
                    end
                end
                pend = rose;
                d2 = d1; d1 = raw;
                sw2 = sw1; sw1 = Switches;
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge Clk);
            chk("cyc_A", 32'($unsigned(A)), 32'(m_a));
            chk("cyc_B", 32'($unsigned(B)), 32'(m_b));
            chk("cyc_Op", 32'(Op), 32'(m_op));
            chk("cyc_Loaded", 32'(Loaded), 32'(m_loaded));
            chk("cyc_Ready", 32'(Ready), 32'(&m_loaded));
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge Clk);
    endtask

    initial begin : stim
        int hold [3];
        #1 Rst_n = 1'b0;
        #2;
        chk("rst_A", 32'($unsigned(A)), 32'h0);
        chk("rst_B", 32'($unsigned(B)), 32'h0);
        chk("rst_Op", 32'(Op), 32'h0);
        chk("rst_Loaded", 32'(Loaded), 32'h0);
        chk("rst_Ready", 32'(Ready), 32'h0);
        wait_neg(2);
        Rst_n = 1'b1;

        // Clean press on A, then a long hold with changing switches.
        @(negedge Clk); Switches = 8'h5A; BtnA = 1'b1;
        wait_neg(6); #1;
        chk("press_edge6_A", 32'($unsigned(A)), 32'h0);
        wait_neg(1); #1;
        chk("press_edge7_A", 32'($unsigned(A)), 32'h5A);
        chk("press_Loaded", 32'(Loaded), 32'h1);
        chk("press_B", 32'($unsigned(B)), 32'h0);
        chk("press_Op", 32'(Op), 32'h0);
        for (int i = 0; i < 20; i++) begin @(negedge Clk); Switches = 8'($urandom); end
        #1;
        chk("hold_A", 32'($unsigned(A)), 32'h5A);
        chk("hold_model_A", 32'(m_a), 32'h5A);
        chk("hold_loads_A", 32'(m_loads[0]), 32'd1);
        @(negedge Clk); BtnA = 1'b0;
        wait_neg(10);

        // Bouncing B: runs of two high samples never qualify.
        Switches = 8'h3C;
        for (int i = 0; i < 5; i++) begin
            BtnB = 1'b1; wait_neg(2);
            BtnB = 1'b0; wait_neg(1);
        end
        BtnB = 1'b1;
        wait_neg(6); #1;
        chk("bounce_edge6_B", 32'($unsigned(B)), 32'h0);
        wait_neg(1); #1;
        chk("bounce_B", 32'($unsigned(B)), 32'h3C);
        chk("bounce_loads_B", 32'(m_loads[1]), 32'd1);
        chk("bounce_Loaded", 32'(Loaded), 32'h3);
        @(negedge Clk); BtnB = 1'b0;
        wait_neg(10);

        // Fresh start, then B and Op pressed together.
        Rst_n = 1'b0; @(negedge Clk); Rst_n = 1'b1;
        @(negedge Clk); Switches = 8'h22; BtnB = 1'b1; BtnOp = 1'b1;
        wait_neg(6); #1;
        chk("simul_edge6_Op", 32'(Op), 32'h0);
        wait_neg(1); #1;
        chk("simul_B", 32'($unsigned(B)), 32'h22);
        chk("simul_Op", 32'(Op), 32'h22);
        chk("simul_Loaded", 32'(Loaded), 32'h6);
        chk("simul_Ready", 32'(Ready), 32'h0);
        @(negedge Clk); BtnB = 1'b0; BtnOp = 1'b0;
        wait_neg(8);
        Switches = 8'h81; BtnA = 1'b1;
        wait_neg(7); #1;
        chk("ready_A", 32'($unsigned(A)), 32'h81);
        chk("ready_Ready", 32'(Ready), 32'h1);

        // Asynchronous reset mid-cycle clears everything without an edge.
        @(negedge Clk); BtnA = 1'b0;
        #2 Rst_n = 1'b0;
        #1;
        chk("async_A", 32'($unsigned(A)), 32'h0);
        chk("async_B", 32'($unsigned(B)), 32'h0);
        chk("async_Op", 32'(Op), 32'h0);
        chk("async_Loaded", 32'(Loaded), 32'h0);
        chk("async_Ready", 32'(Ready), 32'h0);
        @(negedge Clk); Rst_n = 1'b1;
        wait_neg(5);

        // Reset during debounce, button released afterwards: no load.
        Switches = 8'hC3; BtnA = 1'b1;
        wait_neg(3);
        Rst_n = 1'b0;
        @(negedge Clk); Rst_n = 1'b1; BtnA = 1'b0;
        wait_neg(20); #1;
        chk("middeb_A", 32'($unsigned(A)), 32'h0);
        chk("middeb_Loaded", 32'(Loaded), 32'h0);

        // Switch change one edge before the load edge is not yet visible.
        @(negedge Clk); Switches = 8'h0F; BtnA = 1'b1;
        wait_neg(5);
        Switches = 8'hF0;
        wait_neg(2); #1;
        chk("capture_A", 32'($unsigned(A)), 32'h0F);
        @(negedge Clk); BtnA = 1'b0;
        wait_neg(10);

        // Random activity, including resets while buttons are held.
        for (int b = 0; b < 3; b++) hold[b] = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge Clk);
            Switches = 8'($urandom);
            Rst_n = ($urandom_range(0, 249) != 0);
            for (int b = 0; b < 3; b++) begin
                if (hold[b] == 0) begin
                    hold[b] = int'($urandom_range(1, 9));
                    case (b)
                        0: BtnA  = 1'($urandom);
                        1: BtnB  = 1'($urandom);
                        default: BtnOp = 1'($urandom);
                    endcase
                end else begin
                    hold[b]--;
                end
            end
        end
        @(negedge Clk); Rst_n = 1'b1;
        wait_neg(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
